// File: rtl/regfile_write_arbiter.sv
// Register-file write port arbiter: merges non-stallable pipeline writeback with a
// FIFO of long-latency (aux) writes, kills stale queued writes, and reports hazards.
module regfile_write_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     pipe_we,
    input  logic [4:0]               pipe_reg,
    input  logic [31:0]              pipe_data,
    input  logic                     aux_valid,
    output logic                     aux_ready,
    input  logic [4:0]               aux_reg,
    input  logic [31:0]              aux_data,
    input  logic [4:0]               rs,
    input  logic [4:0]               rt,
    output logic                     rs_pending,
    output logic                     rt_pending,
    output logic                     stall_req,
    output logic                     MEM_WB_RegWrite,
    output logic [4:0]               MEM_WB_WriteRegister,
    output logic [31:0]              WB_WriteData,
    output logic [$clog2(DEPTH):0]   queue_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [DEPTH-1:0]       ent_valid, valid_next;
    logic [DEPTH-1:0][4:0]  ent_reg;
    logic [DEPTH-1:0][31:0] ent_data;
    logic [AW-1:0]          rd_ptr, wr_ptr;
    logic [CW-1:0]          count;
    logic [SW-1:0]          starve_cnt, starve_next;

    logic full, empty, pipe_issue, pop, push, head_live;
    logic rs_hit, rt_hit;

    assign full        = (count == CW'(DEPTH));
    assign empty       = (count == '0);
    assign aux_ready   = Rst_n && !full;
    assign pipe_issue  = pipe_we && (pipe_reg != 5'd0);
    assign pop         = !pipe_issue && !empty;
    assign push        = aux_valid && aux_ready && (aux_reg != 5'd0);
    assign head_live   = !empty && ent_valid[rd_ptr];
    assign queue_count = count;

    // A pipe write is always the younger producer, so it kills any queued write
    // to the same register, including one being pushed this very cycle.
    always_comb begin
        valid_next = ent_valid;
        for (int i = 0; i < DEPTH; i++) begin
            if (pop && rd_ptr == AW'(i))
                valid_next[i] = 1'b0;
            if (push && wr_ptr == AW'(i)) begin
                valid_next[i] = !(pipe_issue && aux_reg == pipe_reg);
            end else if (pipe_issue && ent_reg[i] == pipe_reg) begin
                valid_next[i] = 1'b0;
            end
        end
    end

    always_comb begin
        starve_next = starve_cnt;
        if (pop || empty)
            starve_next = '0;
        else if (pipe_issue && starve_cnt < SW'(STARVE_LIMIT))
            starve_next = starve_cnt + SW'(1);
    end

    always_comb begin
        rs_hit = 1'b0;
        rt_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && ent_reg[i] == rs) rs_hit = 1'b1;
            if (ent_valid[i] && ent_reg[i] == rt) rt_hit = 1'b1;
        end
        rs_pending = (rs != 5'd0) &&
                     (rs_hit || (MEM_WB_RegWrite && MEM_WB_WriteRegister == rs));
        rt_pending = (rt != 5'd0) &&
                     (rt_hit || (MEM_WB_RegWrite && MEM_WB_WriteRegister == rt));
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ent_valid            <= '0;
            rd_ptr               <= '0;
            wr_ptr               <= '0;
            count                <= '0;
            starve_cnt           <= '0;
            stall_req            <= 1'b0;
            MEM_WB_RegWrite      <= 1'b0;
            MEM_WB_WriteRegister <= 5'd0;
            WB_WriteData         <= 32'd0;
        end else begin
            ent_valid  <= valid_next;
            count      <= count + CW'(push) - CW'(pop);
            starve_cnt <= starve_next;
            stall_req  <= (starve_next == SW'(STARVE_LIMIT));
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (pipe_issue) begin
                MEM_WB_RegWrite      <= 1'b1;
                MEM_WB_WriteRegister <= pipe_reg;
                WB_WriteData         <= pipe_data;
            end else if (head_live) begin
                MEM_WB_RegWrite      <= 1'b1;
                MEM_WB_WriteRegister <= ent_reg[rd_ptr];
                WB_WriteData         <= ent_data[rd_ptr];
            end else begin
                MEM_WB_RegWrite      <= 1'b0;
            end
        end
    end

    // Payload storage needs no reset; liveness is tracked by ent_valid.
    always_ff @(posedge Clk) begin
        if (push) begin
            ent_reg[wr_ptr]  <= aux_reg;
            ent_data[wr_ptr] <= aux_data;
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed vector bench for regfile_write_arbiter: table of per-cycle stimulus with
// expected post-edge state, plus hand sequences for starvation and mid-run reset.
module tb_regfile_write_arbiter;
    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        pipe_we, aux_valid, aux_ready;
    logic [4:0]  pipe_reg, aux_reg, rs, rt;
    logic [31:0] pipe_data, aux_data;
    logic        rs_pending, rt_pending, stall_req, MEM_WB_RegWrite;
    logic [4:0]  MEM_WB_WriteRegister;
    logic [31:0] WB_WriteData;
    logic [2:0]  queue_count;

    int tests = 0;
    int fails = 0;

    regfile_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .pipe_we(pipe_we), .pipe_reg(pipe_reg), .pipe_data(pipe_data),
        .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_reg(aux_reg), .aux_data(aux_data),
        .rs(rs), .rt(rt), .rs_pending(rs_pending), .rt_pending(rt_pending),
        .stall_req(stall_req), .MEM_WB_RegWrite(MEM_WB_RegWrite),
        .MEM_WB_WriteRegister(MEM_WB_WriteRegister), .WB_WriteData(WB_WriteData),
        .queue_count(queue_count)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        pwe;
        logic [4:0]  preg;
        logic [31:0] pdata;
        logic        av;
        logic [4:0]  areg;
        logic [31:0] adata;
        logic [4:0]  prs, prt;
        logic        e_we;
        logic [4:0]  e_reg;
        logic [31:0] e_data;
        logic        e_rdy;
        logic [2:0]  e_cnt;
        logic        e_rsp, e_rtp, e_stall;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(logic pwe_i, logic [4:0] preg_i, logic [31:0] pdata_i,
                                logic av_i, logic [4:0] areg_i, logic [31:0] adata_i,
                                logic [4:0] rs_i, logic [4:0] rt_i,
                                logic we_o, logic [4:0] reg_o, logic [31:0] data_o,
                                logic rdy_o, logic [2:0] cnt_o, logic rsp_o, logic rtp_o);
        vec_t v;
        v.pwe = pwe_i; v.preg = preg_i; v.pdata = pdata_i;
        v.av = av_i; v.areg = areg_i; v.adata = adata_i;
        v.prs = rs_i; v.prt = rt_i;
        v.e_we = we_o; v.e_reg = reg_o; v.e_data = data_o;
        v.e_rdy = rdy_o; v.e_cnt = cnt_o; v.e_rsp = rsp_o; v.e_rtp = rtp_o;
        v.e_stall = 1'b0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pwe_i, input logic [4:0] preg_i, input logic [31:0] pdata_i,
                         input logic av_i, input logic [4:0] areg_i, input logic [31:0] adata_i);
        pipe_we = pwe_i; pipe_reg = preg_i; pipe_data = pdata_i;
        aux_valid = av_i; aux_reg = areg_i; aux_data = adata_i;
    endtask

    task automatic cycle();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        rs = 0; rt = 0;
        Rst_n = 1'b0;
        #1;
        chk("reset_ready_low", {31'd0, aux_ready}, 32'd0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        #1;
        chk("reset_regwrite", {31'd0, MEM_WB_RegWrite}, 32'd0);
        chk("reset_wreg", {27'd0, MEM_WB_WriteRegister}, 32'd0);
        chk("reset_wdata", WB_WriteData, 32'd0);
        chk("reset_count", {29'd0, queue_count}, 32'd0);
        chk("reset_stall", {31'd0, stall_req}, 32'd0);
        chk("reset_ready", {31'd0, aux_ready}, 32'd1);

        //           pwe preg pdata          av areg adata  rs  rt  | we reg data         rdy cnt rsp rtp
        vecs[0]  = mk(1, 5, 32'hDEADBEEF,    0, 0,  0,      5,  0,    1, 5, 32'hDEADBEEF, 1, 0, 1, 0);
        vecs[1]  = mk(0, 0, 0,               0, 0,  0,      5,  0,    0, 0, 0,            1, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0,               1, 3,  32'h11, 4,  0,    0, 0, 0,            1, 1, 0, 0);
        vecs[3]  = mk(0, 0, 0,               1, 4,  32'h22, 4,  0,    1, 3, 32'h11,       1, 1, 1, 0);
        vecs[4]  = mk(0, 0, 0,               0, 0,  0,      4,  0,    1, 4, 32'h22,       1, 0, 1, 0);
        vecs[5]  = mk(0, 0, 0,               0, 0,  0,      4,  0,    0, 0, 0,            1, 0, 0, 0);
        vecs[6]  = mk(1, 20, 32'hA0,         1, 1,  32'h1,  0,  0,    1, 20, 32'hA0,      1, 1, 0, 0);
        vecs[7]  = mk(1, 20, 32'hA1,         1, 2,  32'h2,  0,  0,    1, 20, 32'hA1,      1, 2, 0, 0);
        vecs[8]  = mk(1, 20, 32'hA2,         1, 6,  32'h6,  0,  0,    1, 20, 32'hA2,      1, 3, 0, 0);
        vecs[9]  = mk(1, 20, 32'hA3,         1, 8,  32'h8,  0,  0,    1, 20, 32'hA3,      0, 4, 0, 0);
        vecs[10] = mk(1, 20, 32'hA4,         1, 11, 32'hB,  11, 8,    1, 20, 32'hA4,      0, 4, 0, 1);
        vecs[11] = mk(0, 0, 0,               1, 11, 32'hB,  11, 0,    1, 1, 32'h1,        1, 3, 0, 0);
        vecs[12] = mk(0, 0, 0,               0, 0,  0,      0,  0,    1, 2, 32'h2,        1, 2, 0, 0);
        vecs[13] = mk(0, 0, 0,               0, 0,  0,      0,  0,    1, 6, 32'h6,        1, 1, 0, 0);
        vecs[14] = mk(0, 0, 0,               0, 0,  0,      0,  8,    1, 8, 32'h8,        1, 0, 0, 1);
        vecs[15] = mk(0, 0, 0,               1, 7,  32'h1,  0,  7,    0, 0, 0,            1, 1, 0, 1);
        vecs[16] = mk(1, 7, 32'h2,           0, 0,  0,      0,  7,    1, 7, 32'h2,        1, 1, 0, 1);
        vecs[17] = mk(0, 0, 0,               0, 0,  0,      0,  7,    0, 0, 0,            1, 0, 0, 0);
        vecs[18] = mk(0, 0, 0,               0, 0,  0,      0,  7,    0, 0, 0,            1, 0, 0, 0);
        vecs[19] = mk(1, 12, 32'h5,          1, 12, 32'h9,  12, 0,    1, 12, 32'h5,       1, 1, 1, 0);
        vecs[20] = mk(0, 0, 0,               0, 0,  0,      12, 0,    0, 0, 0,            1, 0, 0, 0);
        vecs[21] = mk(1, 0, 32'h77,          1, 0,  32'h5,  0,  0,    0, 0, 0,            1, 0, 0, 0);
        vecs[22] = mk(1, 0, 32'h78,          1, 13, 32'h13, 13, 0,    0, 0, 0,            1, 1, 1, 0);
        vecs[23] = mk(1, 0, 32'h79,          0, 0,  0,      13, 0,    1, 13, 32'h13,      1, 0, 1, 0);

        for (int i = 0; i < 24; i++) begin
            @(negedge Clk);
            drive(vecs[i].pwe, vecs[i].preg, vecs[i].pdata, vecs[i].av, vecs[i].areg, vecs[i].adata);
            rs = vecs[i].prs; rt = vecs[i].prt;
            cycle();
            chk($sformatf("v%0d_regwrite", i), {31'd0, MEM_WB_RegWrite}, {31'd0, vecs[i].e_we});
            if (vecs[i].e_we) begin
                chk($sformatf("v%0d_wreg", i), {27'd0, MEM_WB_WriteRegister}, {27'd0, vecs[i].e_reg});
                chk($sformatf("v%0d_wdata", i), WB_WriteData, vecs[i].e_data);
            end
            chk($sformatf("v%0d_ready", i), {31'd0, aux_ready}, {31'd0, vecs[i].e_rdy});
            chk($sformatf("v%0d_count", i), {29'd0, queue_count}, {29'd0, vecs[i].e_cnt});
            chk($sformatf("v%0d_rs_pend", i), {31'd0, rs_pending}, {31'd0, vecs[i].e_rsp});
            chk($sformatf("v%0d_rt_pend", i), {31'd0, rt_pending}, {31'd0, vecs[i].e_rtp});
            chk($sformatf("v%0d_stall", i), {31'd0, stall_req}, {31'd0, vecs[i].e_stall});
        end

        // Starvation: one queued entry blocked by 8 pipe writes raises stall_req.
        @(negedge Clk);
        drive(0, 0, 0, 1, 10, 32'hAA);
        rs = 0; rt = 0;
        cycle();
        chk("starve_push_count", {29'd0, queue_count}, 32'd1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge Clk);
            drive(1, 9, 32'h90 + k, 0, 0, 0);
            cycle();
            chk($sformatf("starve_stall_%0d", k), {31'd0, stall_req}, (k == 8) ? 32'd1 : 32'd0);
        end
        @(negedge Clk);
        drive(1, 9, 32'h99, 0, 0, 0);
        cycle();
        chk("starve_pipe_wins_we", {31'd0, MEM_WB_RegWrite}, 32'd1);
        chk("starve_pipe_wins_reg", {27'd0, MEM_WB_WriteRegister}, 32'd9);
        chk("starve_pipe_wins_data", WB_WriteData, 32'h99);
        chk("starve_still_stall", {31'd0, stall_req}, 32'd1);
        @(negedge Clk);
        drive(0, 0, 0, 0, 0, 0);
        cycle();
        chk("starve_drain_reg", {27'd0, MEM_WB_WriteRegister}, 32'd10);
        chk("starve_drain_data", WB_WriteData, 32'hAA);
        chk("starve_stall_clear", {31'd0, stall_req}, 32'd0);
        chk("starve_drain_count", {29'd0, queue_count}, 32'd0);

        // Reset mid-operation discards three queued writes.
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            drive(1, 20, 32'hC0 + k, 1, 5'(21 + k), 32'hE0 + k);
            cycle();
        end
        chk("rst_pre_count", {29'd0, queue_count}, 32'd3);
        chk("rst_pre_we", {31'd0, MEM_WB_RegWrite}, 32'd1);
        @(negedge Clk);
        drive(0, 0, 0, 0, 0, 0);
        rs = 21; rt = 0;
        Rst_n = 1'b0;
        #1;
        chk("rst_async_we", {31'd0, MEM_WB_RegWrite}, 32'd0);
        chk("rst_async_wreg", {27'd0, MEM_WB_WriteRegister}, 32'd0);
        chk("rst_async_wdata", WB_WriteData, 32'd0);
        chk("rst_async_count", {29'd0, queue_count}, 32'd0);
        chk("rst_async_ready", {31'd0, aux_ready}, 32'd0);
        chk("rst_async_rs_pend", {31'd0, rs_pending}, 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk($sformatf("rst_after_we_%0d", k), {31'd0, MEM_WB_RegWrite}, 32'd0);
        end
        chk("rst_after_count", {29'd0, queue_count}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Writer side of the register-file write port. Merges two sources of register writes into the single port driven by MEM_WB_RegWrite, MEM_WB_WriteRegister and WB_WriteData.
- Source 1 is the in-order pipeline writeback, which is non-stallable.
- Source 2 is long-latency units such as mul/div or per-core shared resources. These use a valid/ready handshake and are buffered in a small FIFO.
- The block also reports pending-write hazards on rs/rt to the hazard unit.

Parameters:
DEPTH, 4, aux FIFO entries; power of 2, minimum 2
STARVE_LIMIT, 8, consecutive cycles in which a non-empty FIFO is blocked by pipeline writes before stall_req asserts

Ports:
Clk  input  1  clock; all state updates on posedge
Rst_n  input  1  asynchronous active-low reset
pipe_we  input  1  pipeline writeback valid
pipe_reg  input  5  pipeline destination register
pipe_data  input  32  pipeline write data
aux_valid  input  1  aux write request
aux_ready  output  1  FIFO can accept; equals !full, forced 0 while Rst_n low
aux_reg  input  5  aux destination register
aux_data  input  32  aux write data
rs  input  5  source register probe
rt  input  5  source register probe
rs_pending  output  1  a live queued or in-flight write targets rs (0 when rs==0)
rt_pending  output  1  same, for rt
stall_req  output  1  registered; requests that the pipeline hold off writeback
MEM_WB_RegWrite  output  1  register-file write enable
MEM_WB_WriteRegister  output  5  register-file write index
WB_WriteData  output  32  register-file write data
queue_count  output  log2(DEPTH)+1  live plus killed entries held in the FIFO

Behaviour:
- Reset (async, Rst_n low):
  - MEM_WB_RegWrite=0, MEM_WB_WriteRegister=0, WB_WriteData=0.
  - FIFO emptied (queue_count=0), all entry valid bits cleared.
  - stall_req=0, starve counter=0.
  - Reset mid-operation discards all queued writes.
- Output timing: outputs are registered, so a write selected in cycle N drives the port during cycle N+1.
- Per-cycle selection, in priority order:
  1. If pipe_we && pipe_reg!=0, issue the pipe write. A pipe write to r0 is ignored and counts as no pipe write.
  2. Else, if the FIFO head is live, pop it and issue it.
  3. Else, if the FIFO head is killed, pop it and issue nothing (MEM_WB_RegWrite=0).
  4. Else, MEM_WB_RegWrite=0.
- Push:
  - Occurs when aux_valid && aux_ready.
  - aux_ready depends only on the registered count; push when full is impossible, even in a cycle that pops.
  - aux_reg==0: handshake completes, nothing is enqueued.
  - Push and pop in the same cycle: count unchanged. The pushed entry is never the one popped that cycle.
- Kill rule (WAW): the pipeline write is always the younger producer.
  - An issued pipe write to register R clears the valid bit of every FIFO entry holding R.
  - This includes an entry pushed in the same cycle.
- Pending:
  - rs_pending = (rs!=0) && (any live FIFO entry has reg==rs, or MEM_WB_RegWrite && MEM_WB_WriteRegister==rs).
  - rt_pending is defined the same way.
  - Both are combinational from state and the probe inputs.
- Starvation:
  - The counter increments each cycle a pipe write issues while the FIFO is non-empty.
  - It clears on any pop or whenever the FIFO is empty, and saturates at STARVE_LIMIT.
  - stall_req sets the cycle after the counter reaches STARVE_LIMIT and clears the cycle after a pop.
  - If pipe_we arrives while stall_req=1, the pipe write still wins.
- Pointers wrap modulo DEPTH. Full means count==DEPTH; empty means count==0.

Test Plan:
- Reset, then pipe_we=1, pipe_reg=5, pipe_data=0xDEADBEEF for one cycle -> next cycle MEM_WB_RegWrite=1, MEM_WB_WriteRegister=5, WB_WriteData=0xDEADBEEF; following cycle RegWrite=0.
- Push aux writes r3=0x11, r4=0x22 with pipe idle -> port issues r3 then r4 in consecutive cycles, in order; rs=4 gives rs_pending=1 until the r4 write leaves the port.
- Fill FIFO with 4 entries -> aux_ready=0, queue_count=4. A fifth aux_valid is not accepted. One pop -> aux_ready=1 next cycle.
- Queue r7=0x1; pipe writes r7=0x2 before it drains -> port issues only r7=0x2. Killed entry pops with RegWrite=0; rt=7 shows rt_pending=0 after the pipe write leaves the port.
- Queue one entry, hold pipe_we=1 (reg 9) for 8 cycles -> stall_req=1. Drop pipe_we -> entry issues, stall_req=0 the cycle after the pop.
- Assert Rst_n=0 with 3 queued entries -> outputs 0 immediately, queue_count=0. After release, no queued write ever appears on the port.
